// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared widths and FSM encoding for the SPI command arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
package spi_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/spi_cmd_arbiter_rr_pick.sv
// Round-robin winner select: first requester after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to accept the pick.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_i;

  // Scan from the farthest candidate back to last_grant+1 so the nearest wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    cand   = 0;
    cand_i = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand   = (int'(last_grant) + k) % NUM_REQ;
      cand_i = IDX_W'(cand);
      if (req[cand_i]) begin
        grant         = '0;
        grant[cand_i] = 1'b1;
        idx           = cand_i;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI register engine between NUM_REQ requesters.
// Latency: command 1 cycle after request; usr_ack 1 cycle after engine ack or timeout.
// Backpressure: requests are level-held until usr_ack; one transaction in flight at a time.
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        usr_req,
  input  logic [NUM_REQ-1:0]        usr_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] usr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] usr_wdata,
  output logic [NUM_REQ-1:0]        usr_ack,
  output logic                      usr_err,
  output logic [DATA_W-1:0]         usr_rdata,
  output logic                      busy,
  output logic                      timeout_flag,
  output logic                      cmd_read,
  output logic                      cmd_write,
  input  logic                      cmd_read_ack,
  input  logic                      cmd_write_ack,
  output logic [ADDR_W-1:0]         read_addr,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_wr;
  logic [CNT_W-1:0]   wait_cnt;
  logic               any_req;
  logic               ack_hit;
  logic               to_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (usr_req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  assign any_req = |usr_req;
  // Only the ack matching the issued command counts; the other one is noise.
  assign ack_hit = win_wr ? cmd_write_ack : cmd_read_ack;
  assign to_hit  = (TIMEOUT_CYC != 0) && (wait_cnt >= CNT_W'(TIMEOUT_CYC));
  // State is registered, so busy is glitch-free and spans grant through the ack cycle.
  assign busy    = (state != IDLE);

  // Next-state selection; an engine ack takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = WAIT;
      WAIT:    if (ack_hit || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant latching, command drive, watchdog and completion reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= IDX_W'(NUM_REQ - 1);
      win_idx      <= '0;
      win_oh       <= '0;
      win_wr       <= 1'b0;
      wait_cnt     <= '0;
      cmd_read     <= 1'b0;
      cmd_write    <= 1'b0;
      read_addr    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      usr_ack      <= '0;
      usr_err      <= 1'b0;
      usr_rdata    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      usr_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_idx    <= pick_idx;
            win_oh     <= pick_grant;
            win_wr     <= usr_wr[pick_idx];
            read_addr  <= usr_addr[pick_idx*ADDR_W +: ADDR_W];
            write_addr <= usr_addr[pick_idx*ADDR_W +: ADDR_W];
            write_data <= usr_wdata[pick_idx*DATA_W +: DATA_W];
            cmd_write  <= usr_wr[pick_idx];
            cmd_read   <= ~usr_wr[pick_idx];
            wait_cnt   <= '0;
          end
        end
        WAIT: begin
          if (ack_hit) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            usr_err   <= 1'b0;
            usr_ack   <= win_oh;
            if (!win_wr) usr_rdata <= read_data;
          end else if (to_hit) begin
            cmd_read     <= 1'b0;
            cmd_write    <= 1'b0;
            usr_err      <= 1'b1;
            usr_rdata    <= '0;
            timeout_flag <= 1'b1;
            usr_ack      <= win_oh;
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          last_grant <= win_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
